cla_arb_seq: RTL and testbench

CLA_ARB_SEQ -- requirements
Module: cla_arb_seq

---
 rtl/cla_arb_seq_pkg.sv | 21 ++
 rtl/cla_arb_seq_cla8.sv | 43 ++++
 rtl/cla_arb_seq.sv | 157 +++++++++++++++
 tb/tb_cla_arb_seq.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_arb_seq_pkg.sv
// Shared ALU constants: op codes and arbiter FSM encodings.
// Imported by the arbiter top and its CLA_8 adder.
package cla_arb_seq_pkg;

    localparam int CLA_W = 8;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_RSV = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_MUL  = 2'b10,
        S_DONE = 2'b11
    } arb_state_e;

endpackage

// File: rtl/cla_arb_seq_cla8.sv
// 8-bit carry-lookahead adder/subtractor shared by all arbiter operations.
// Outputs are zero when neither enable is asserted.
module cla_arb_seq_cla8
    import cla_arb_seq_pkg::*;
(
    input  logic [CLA_W-1:0] a,
    input  logic [CLA_W-1:0] b,
    input  logic             cin,
    input  logic             enable_add,
    input  logic             enable_sub,
    output logic [CLA_W-1:0] sum,
    output logic             cout
);

    logic [CLA_W-1:0] b_eff;
    logic [CLA_W-1:0] g;
    logic [CLA_W-1:0] p;
    logic [CLA_W:0]   carry;

    always_comb begin
        b_eff    = enable_sub ? ~b : b;
        g        = a & b_eff;
        p        = a ^ b_eff;
        carry    = '0;
        carry[0] = enable_sub ? 1'b1 : cin;
        // each carry is expanded from c0 through its own g/p terms
        for (int i = 0; i < CLA_W; i++) begin
            logic t;
            t = carry[0];
            for (int j = 0; j <= i; j++) begin
                t = g[j] | (p[j] & t);
            end
            carry[i+1] = t;
        end
        sum  = p ^ carry[CLA_W-1:0];
        cout = carry[CLA_W];
        if (!(enable_add || enable_sub)) begin
            sum  = '0;
            cout = 1'b0;
        end
    end

endmodule

// File: rtl/cla_arb_seq.sv
// Two-requester round-robin arbiter sequencing add, sub and
// shift-add multiply on a single shared CLA_8.
module cla_arb_seq
    import cla_arb_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0,
    input  logic                 req1,
    input  logic [1:0]           op0,
    input  logic [1:0]           op1,
    input  logic [WIDTH-1:0]     a0,
    input  logic [WIDTH-1:0]     b0,
    input  logic [WIDTH-1:0]     a1,
    input  logic [WIDTH-1:0]     b1,
    output logic                 ack0,
    output logic                 ack1,
    output logic [2*WIDTH-1:0]   result,
    output logic                 cout,
    output logic                 busy,
    output logic                 grant_id
);

    arb_state_e           state_q, state_d;
    alu_op_e              op_q, op_d, win_op;
    logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]     win_a, win_b;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic [2:0]           cnt_q, cnt_d;
    logic                 cout_q, cout_d;
    logic                 grant_q, grant_d;
    logic                 ptr_q, ptr_d;
    logic                 win;

    logic [WIDTH-1:0]     add_a, add_b, add_sum;
    logic                 add_en, sub_en, add_co;
    logic [WIDTH:0]       mul_hi;

    assign win    = (req0 && req1) ? ptr_q : req1;
    assign win_op = alu_op_e'(win ? op1 : op0);
    assign win_a  = win ? a1 : a0;
    assign win_b  = win ? b1 : b0;

    always_comb begin
        add_a  = a_q;
        add_b  = b_q;
        add_en = 1'b0;
        sub_en = 1'b0;
        unique case (state_q)
            S_EXEC: begin
                add_en = (op_q == OP_ADD);
                sub_en = (op_q == OP_SUB);
            end
            S_MUL: begin
                add_a  = acc_q[2*WIDTH-1:WIDTH];
                add_en = 1'b1;
            end
            default: ;
        endcase
    end

    // Multiplier bits sit in the low byte and are consumed from bit 0;
    // shifting right each step aligns b with bit i of the product.
    assign mul_hi = acc_q[0] ? {add_co, add_sum}
                             : {1'b0, acc_q[2*WIDTH-1:WIDTH]};

    cla_arb_seq_cla8 u_cla (
        .a          (add_a),
        .b          (add_b),
        .cin        (1'b0),
        .enable_add (add_en),
        .enable_sub (sub_en),
        .sum        (add_sum),
        .cout       (add_co)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        cout_d   = cout_q;
        grant_d  = grant_q;
        ptr_d    = ptr_q;
        unique case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    grant_d = win;
                    ptr_d   = ~win;
                    op_d    = win_op;
                    a_d     = win_a;
                    b_d     = win_b;
                    acc_d   = {{WIDTH{1'b0}}, win_a};
                    cnt_d   = 3'd0;
                    state_d = (win_op == OP_MUL) ? S_MUL : S_EXEC;
                end
            end
            S_EXEC: begin
                result_d = {{WIDTH{1'b0}}, add_sum};
                cout_d   = add_co;
                state_d  = S_DONE;
            end
            S_MUL: begin
                acc_d = {mul_hi, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    result_d = {mul_hi, acc_q[WIDTH-1:1]};
                    cout_d   = 1'b0;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= OP_ADD;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            grant_q  <= 1'b0;
            ptr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            grant_q  <= grant_d;
            ptr_q    <= ptr_d;
        end
    end

    assign ack0     = (state_q == S_DONE) && !grant_q;
    assign ack1     = (state_q == S_DONE) && grant_q;
    assign busy     = (state_q != S_IDLE);
    assign result   = result_q;
    assign cout     = cout_q;
    assign grant_id = grant_q;

endmodule

// File: tb/tb_cla_arb_seq.sv
// Self-checking bench for cla_arb_seq: directed vector table,
// hand-written arbitration/reset sequences and a randomized model run.
module tb_cla_arb_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1;
    logic [1:0]  op0, op1;
    logic [7:0]  a0, b0, a1, b1;
    logic        ack0, ack1;
    logic [15:0] result;
    logic        cout;
    logic        busy;
    logic        grant_id;

    int n_cmp = 0;
    int n_err = 0;

    // Model-side expected result, carry and priority pointer.
    logic [15:0] last_res;
    logic        last_co;
    logic        mptr;

    typedef struct {
        logic        who;
        logic [1:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] res;
        logic        co;
        int          lat;
        logic        pert;
    } vec_t;

    vec_t tbl[12];

    cla_arb_seq #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .req0     (req0),
        .req1     (req1),
        .op0      (op0),
        .op1      (op1),
        .a0       (a0),
        .b0       (b0),
        .a1       (a1),
        .b1       (b1),
        .ack0     (ack0),
        .ack1     (ack1),
        .result   (result),
        .cout     (cout),
        .busy     (busy),
        .grant_id (grant_id)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running want done");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic void ref_calc(input logic [1:0] op,
                                     input logic [7:0] a,
                                     input logic [7:0] b,
                                     output logic [15:0] r,
                                     output logic co,
                                     output int lat);
        int s;
        lat = 3;
        r   = 16'd0;
        co  = 1'b0;
        case (op)
            2'd0: begin
                s  = int'(a) + int'(b);
                r  = 16'(s % 256);
                co = (s > 255);
            end
            2'd1: begin
                s  = int'(a) - int'(b) + 256;
                r  = 16'(s % 256);
                co = (a >= b);
            end
            2'd2: begin
                r   = 16'(int'(a) * int'(b));
                lat = 10;
            end
            default: ;
        endcase
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ack0"}, 32'(ack0), 0);
        chk({tag, "_ack1"}, 32'(ack1), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_result"}, 32'(result), 0);
        chk({tag, "_cout"}, 32'(cout), 0);
        chk({tag, "_grant"}, 32'(grant_id), 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        req0 = 0; req1 = 0;
        #1 chk_reset_vals("rst_async");
        @(posedge clk);
        @(negedge clk);
        chk_reset_vals("rst_hold");
        @(posedge clk);
        #1 rst = 1'b0;
        last_res = 16'd0;
        last_co  = 1'b0;
        mptr     = 1'b0;
    endtask

    // Called one step after a rising edge, with the DUT in IDLE.
    task automatic do_txn(input logic r0, input logic r1,
                          input logic [1:0] o0, input logic [1:0] o1,
                          input logic [7:0] xa0, input logic [7:0] xb0,
                          input logic [7:0] xa1, input logic [7:0] xb1,
                          input logic pert, input logic drop,
                          input logic who, input logic [15:0] eres,
                          input logic eco, input int elat);
        int  lat;
        bit  got;
        req0 = r0; req1 = r1;
        op0 = o0; op1 = o1;
        a0 = xa0; b0 = xb0; a1 = xa1; b1 = xb1;
        got = 0;
        lat = 0;
        for (int cyc = 1; cyc <= 15; cyc++) begin
            @(negedge clk);
            if (ack0 || ack1) begin
                got = 1;
                lat = cyc;
                break;
            end
            chk("busy_during", 32'(busy), 32'(cyc > 1));
            chk("result_hold", 32'(result), 32'(last_res));
            chk("cout_hold", 32'(cout), 32'(last_co));
            if (pert && cyc == 2) begin
                a0 = ~a0; a1 = ~a1;
                b0 = b0 + 8'd1; b1 = b1 + 8'd1;
                op0 = op0 ^ 2'b10; op1 = op1 ^ 2'b10;
                req0 = 0; req1 = 0;
            end
        end
        chk("ack_seen", 32'(got), 1);
        if (got) begin
            chk("latency", 32'(lat), 32'(elat));
            chk("ack_vec", 32'({ack1, ack0}), who ? 32'd2 : 32'd1);
            chk("grant_id", 32'(grant_id), 32'(who));
            chk("busy_done", 32'(busy), 1);
            chk("result", 32'(result), 32'(eres));
            chk("cout", 32'(cout), 32'(eco));
        end
        last_res = eres;
        last_co  = eco;
        mptr     = ~who;
        @(posedge clk);
        #1;
        if (drop) begin
            req0 = 0; req1 = 0;
            @(negedge clk);
            chk("idle_ack", 32'({ack1, ack0}), 0);
            chk("idle_busy", 32'(busy), 0);
            chk("idle_grant", 32'(grant_id), 32'(who));
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [15:0] er;
        logic        ec;
        int          el;
        logic        r0, r1, w;
        logic [1:0]  o0, o1;
        logic [7:0]  x0, y0, x1, y1;

        tbl[0]  = '{0, 2'd0, 8'd12,  8'd6,   16'd18,    0, 3,  0};
        tbl[1]  = '{1, 2'd1, 8'd8,   8'd5,   16'd3,     1, 3,  0};
        tbl[2]  = '{1, 2'd1, 8'd5,   8'd8,   16'h00FD,  0, 3,  0};
        tbl[3]  = '{0, 2'd0, 8'd200, 8'd100, 16'd44,    1, 3,  0};
        tbl[4]  = '{0, 2'd2, 8'd255, 8'd255, 16'd65025, 0, 10, 0};
        tbl[5]  = '{0, 2'd3, 8'd77,  8'd33,  16'd0,     0, 3,  0};
        tbl[6]  = '{0, 2'd0, 8'd10,  8'd20,  16'd30,    0, 3,  1};
        tbl[7]  = '{1, 2'd2, 8'd13,  8'd11,  16'd143,   0, 10, 1};
        tbl[8]  = '{1, 2'd1, 8'd0,   8'd0,   16'd0,     1, 3,  0};
        tbl[9]  = '{0, 2'd2, 8'd0,   8'd200, 16'd0,     0, 10, 0};
        tbl[10] = '{1, 2'd0, 8'd255, 8'd1,   16'd0,     1, 3,  0};
        tbl[11] = '{1, 2'd3, 8'd5,   8'd9,   16'd0,     0, 3,  1};

        rst = 1'b1;
        req0 = 0; req1 = 0;
        op0 = 0; op1 = 0;
        a0 = 0; b0 = 0; a1 = 0; b1 = 0;
        #1 chk_reset_vals("por");
        do_reset();

        for (int i = 0; i < 12; i++) begin
            do_txn(!tbl[i].who, tbl[i].who, tbl[i].op, tbl[i].op,
                   tbl[i].a, tbl[i].b, tbl[i].a, tbl[i].b,
                   tbl[i].pert, 1, tbl[i].who, tbl[i].res,
                   tbl[i].co, tbl[i].lat);
        end

        // Both requesters held from reset: req0, then req1, then req0.
        do_reset();
        do_txn(1, 1, 2'd0, 2'd1, 8'd1, 8'd2, 8'd9, 8'd4,
               0, 0, 0, 16'd3, 0, 3);
        do_txn(1, 1, 2'd0, 2'd1, 8'd1, 8'd2, 8'd9, 8'd4,
               0, 0, 1, 16'd5, 1, 3);
        do_txn(1, 1, 2'd0, 2'd1, 8'd1, 8'd2, 8'd9, 8'd4,
               0, 1, 0, 16'd3, 0, 3);

        // Reset pulsed in cycle 5 of a multiply aborts it without ack.
        req0 = 1; op0 = 2'd2; a0 = 8'd7; b0 = 8'd9;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(negedge clk);
            chk("abort_no_ack", 32'({ack1, ack0}), 0);
        end
        rst = 1'b1;
        #1 chk_reset_vals("abort_async");
        @(posedge clk);
        @(negedge clk);
        chk_reset_vals("abort_hold");
        @(posedge clk);
        #1 rst = 1'b0;
        last_res = 16'd0;
        last_co  = 1'b0;
        mptr     = 1'b0;
        do_txn(1, 0, 2'd2, 2'd0, 8'd7, 8'd9, 8'd0, 8'd0,
               0, 1, 0, 16'd63, 0, 10);

        // Randomized traffic against the arithmetic model.
        do_reset();
        for (int k = 0; k < 40; k++) begin
            r0 = 1'($urandom_range(0, 1));
            r1 = 1'($urandom_range(0, 1));
            if (!r0 && !r1) r0 = 1;
            o0 = 2'($urandom_range(0, 3));
            o1 = 2'($urandom_range(0, 3));
            x0 = 8'($urandom); y0 = 8'($urandom);
            x1 = 8'($urandom); y1 = 8'($urandom);
            w = (r0 && r1) ? mptr : r1;
            if (w) ref_calc(o1, x1, y1, er, ec, el);
            else   ref_calc(o0, x0, y0, er, ec, el);
            do_txn(r0, r1, o0, o1, x0, y0, x1, y1,
                   1'($urandom_range(0, 3) == 0), 1, w, er, ec, el);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
